// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and default baud divisor.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Ports: none (package). Imported by the TX top, its baud counter and the transmit interface.
package uart_pkg;

  // 8N1 frame geometry
  localparam int UART_DATA_BITS  = 8;
  localparam int UART_FRAME_BITS = 10;

  // Default clock cycles per bit period (f_clk / baud), shared by RX and TX
  localparam int UART_CLKS_PER_BAUD = 868;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_if.sv
// Transmit-side bundle: byte valid/ready handshake plus serial line and frame status.
// Latency: n/a (wires only).
// Backpressure: producer holds i_tx_data/i_tx_valid until o_tx_ready is seen high at a clock edge.
// Ports: i_tx_data/i_tx_valid (producer -> TX), o_tx_ready/o_tx/o_tx_busy/o_tx_done (TX -> outside).
interface uart_tx_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] i_tx_data;
  logic                      i_tx_valid;
  logic                      o_tx_ready;
  logic                      o_tx;
  logic                      o_tx_busy;
  logic                      o_tx_done;

  // Producer side
  modport master (
    output i_tx_data, i_tx_valid,
    input  o_tx_ready, o_tx, o_tx_busy, o_tx_done
  );

  // Transmitter side
  modport slave (
    input  i_tx_data, i_tx_valid,
    output o_tx_ready, o_tx, o_tx_busy, o_tx_done
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Loadable baud down-counter; o_tick is high while the count is 0 (end of a bit period).
// Latency: load takes effect on the next cycle; a loaded period lasts exactly CLKS_PER_BAUD cycles.
// Backpressure: none; counter stops at 0 until reloaded or cleared.
// Ports: i_clk, i_rst (sync, active-high), i_load (reload CLKS_PER_BAUD-1), i_clear (force 0,
//        wins over load), o_tick (count == 0), o_tick_next (count == 1, tick due next cycle).
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = UART_CLKS_PER_BAUD
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_clear,
  output logic o_tick,
  output logic o_tick_next
);

  localparam int CW = (CLKS_PER_BAUD > 1) ? $clog2(CLKS_PER_BAUD) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(CLKS_PER_BAUD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = LOAD_VAL;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick      = (cnt_q == '0);
  assign o_tick_next = (cnt_q == CW'(1));

endmodule

// File: rtl/uart_tx.sv
// UART 8N1 transmitter with a one-entry holding register for gap-free streaming.
// Latency: byte accepted while idle at edge k drives the start bit from the cycle after edge k;
//          each frame is 10*CLKS_PER_BAUD cycles.
// Backpressure: o_tx_ready = !hold_full; a held byte blocks further accepts until it is drained.
// Ports: i_clk, i_rst (sync, active-high), tx_if (slave): i_tx_data/i_tx_valid in,
//        o_tx_ready, o_tx (idles high), o_tx_busy, o_tx_done (last stop cycle) out.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BAUD = UART_CLKS_PER_BAUD
) (
  input  logic     i_clk,
  input  logic     i_rst,
  uart_tx_if.slave tx_if
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  uart_state_e               state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] hold_q, hold_d;
  logic                      hold_full_q, hold_full_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;

  logic accept;
  logic bypass;
  logic baud_load;
  logic baud_clear;
  logic tick;
  logic tick_next;

  uart_baud_tick #(
    .CLKS_PER_BAUD(CLKS_PER_BAUD)
  ) u_baud (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (baud_load),
    .i_clear    (baud_clear),
    .o_tick     (tick),
    .o_tick_next(tick_next)
  );

  assign accept = tx_if.i_tx_valid && !hold_full_q;

  // A byte skips the holding register when the shifter is free now (idle) or frees up
  // on this very edge (last stop cycle with nothing already waiting).
  assign bypass = accept &&
                  ((state_q == ST_IDLE) ||
                   ((state_q == ST_STOP) && tick && !hold_full_q));

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    baud_load   = 1'b0;
    baud_clear  = 1'b0;

    if (accept && !bypass) begin
      hold_d      = tx_if.i_tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bypass) begin
          state_d   = ST_START;
          shift_d   = tx_if.i_tx_data;
          baud_load = 1'b1;
        end else begin
          baud_clear = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          state_d   = ST_DATA;
          bit_d     = '0;
          baud_load = 1'b1;
        end
      end

      ST_DATA: begin
        if (tick) begin
          baud_load = 1'b1;
          shift_d   = shift_q >> 1;
          // 3-bit index wraps 7 -> 0 on the way into STOP
          bit_d     = bit_q + 3'd1;
          if (bit_q == LAST_BIT) begin
            state_d = ST_STOP;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (hold_full_q) begin
            state_d     = ST_START;
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            baud_load   = 1'b1;
          end else if (bypass) begin
            state_d   = ST_START;
            shift_d   = tx_if.i_tx_data;
            baud_load = 1'b1;
          end else begin
            state_d    = ST_IDLE;
            baud_clear = 1'b1;
          end
        end
      end

      default: begin
        state_d    = ST_IDLE;
        baud_clear = 1'b1;
      end
    endcase

    // Outputs are registered from the next state so the line changes on the same
    // edge as the FSM rather than one cycle later.
    unique case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
    // STOP is always entered with a reload of at least 1, so count==1 precedes its final cycle
    done_d = (state_q == ST_STOP) && tick_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_q       <= bit_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_if.o_tx_ready = !hold_full_q;
  assign tx_if.o_tx       = tx_q;
  assign tx_if.o_tx_busy  = busy_q;
  assign tx_if.o_tx_done  = done_q;

endmodule
